pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer that supersedes the fixed 8-bit PC in the instruction-fetch path. It advances the PC on a qualified step strobe rather than an internally divided clock. It supports relative branches, absolute jumps, and call/return through an internal return-address stack (RAS). It sits between the decode/control unit, which supplies the control strobes, and the instruction memory, which consumes `pc`.

## Interface
- `ADDR_W`, 8: PC width in bits; all address arithmetic is modulo 2^ADDR_W.
- `RAS_DEPTH`, 4: return-address stack entries, ≥ 2.
- `RESET_PC`, 0: PC value loaded on reset.

- `clk`  in  1: system clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `step`  in  1: advance strobe (one-cycle pulse from the rate generator); no state changes when low.
- `stall`  in  1: when high, the step is ignored and the PC and RAS hold.
- `branch`  in  1: relative branch request.
- `b_offset`  in  ADDR_W: two's-complement branch offset.
- `jump`  in  1: absolute jump request.
- `call`  in  1: jump to `target` and push the return address.
- `ret`  in  1: pop the RAS and jump to the popped address.
- `target`  in  ADDR_W: absolute destination for `jump` and `call`.
- `pc`  out  ADDR_W: current PC, registered.
- `ras_empty`  out  1: RAS holds 0 entries.
- `ras_full`  out  1: RAS holds RAS_DEPTH entries.
- `ras_err`  out  1: sticky flag; set on RAS overflow or underflow, cleared only by reset.

## Operation
- An update occurs only in a cycle with `step`=1 and `stall`=0 (an "active step"). All other cycles hold every register.
- Priority on an active step, highest first: ret > call > jump > branch > sequential. Only the highest asserted request acts; lower requests are discarded.
- Sequential: pc ← pc+1.
- Branch: pc ← pc + b_offset + 1, with b_offset sign-interpreted and the result wrapping mod 2^ADDR_W. Example, ADDR_W=8: pc=0x10, b_offset=0xFE gives 0x0F.
- Jump: pc ← target.
- Call: push pc+1 (wrapped), then pc ← target.
- Call with RAS full: pc ← target; the oldest entry is discarded and the new return address is pushed (circular overwrite); ras_err ← 1.
- Ret: pc ← top of stack; pop.
- Ret with RAS empty: pc ← pc+1 (treated as sequential); the stack is unchanged; ras_err ← 1.
- RAS occupancy ranges 0..RAS_DEPTH. `ras_empty` and `ras_full` are decoded from the registered occupancy count.

## Timing
- Reset, asynchronous, effective immediately: pc=RESET_PC, occupancy=0, ras_empty=1, ras_full=0, ras_err=0. RAS contents are don't-care.
- Reset deasserting mid-operation: the first active step after release acts on pc=RESET_PC. A step coincident with reset is ignored.
- Latency: the `pc` change and the flag updates are visible one clock after the active-step edge. There is no combinational path from inputs to outputs.
- Control inputs are sampled only on the active-step edge. They need not be held between steps.
- `step` high for N consecutive cycles with stall=0 produces N updates. The block does not detect edges.
- A push followed by a pop in adjacent active steps returns the pushed value; there is no bubble.

## Structure
- Shared package `pc_pkg` holds:
  - the internal operation encoding `pc_op_t` (OP_HOLD, OP_SEQ, OP_BRANCH, OP_JUMP, OP_CALL, OP_RET);
  - the priority-encode function mapping requests to `pc_op_t`.
- One sub-module, `ras_stack`: a parametrised LIFO with a circular pointer, an occupancy count, push/pop ports, and full/empty outputs. Overwrite-on-full happens inside the sub-module.
- The top level contains the priority encoder, the next-PC adder/mux, the PC register, and the ras_err register.

## Test plan
- Reset and sequential: ADDR_W=8, RESET_PC=0x00. Step 300 times with no requests: pc goes 0x01…0xFF, then 0x00 after the 256th step, and reads 0x2C after 300 steps; ras_err stays 0.
- Branch and stall: at pc=0x10, branch with b_offset=0x05 gives 0x16; from 0x16, branch with b_offset=0xFE gives 0x15. A step with stall=1 leaves pc=0x15.
- Call/return nesting, RAS_DEPTH=4: from pc=0x20, call target=0x40, then at 0x40 call target=0x60. The next ret gives 0x41 and the following ret gives 0x21; ras_empty=1 at the end.
- Overflow: 5 calls from pcs 0x00, 0x10, 0x20, 0x30, 0x40 (targets each +0x10). ras_err=1 and ras_full=1. Four rets return 0x41, 0x31, 0x21, 0x11; the 0x01 entry is lost.
- Underflow and priority:
  - ret with the RAS empty at pc=0x50 gives 0x51 and ras_err=1;
  - ret+call+jump+branch asserted together with one entry 0x33 gives pc=0x33, no push;
  - jump+branch together gives pc=target.
- Asynchronous reset mid-stream: assert reset between clock edges while pc=0x77 with 2 entries on the RAS. pc=RESET_PC and ras_empty=1 before the next edge; ras_err clears.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: the internal operation
// encoding and the request priority encoder.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_SEQ,
    OP_BRANCH,
    OP_JUMP,
    OP_CALL,
    OP_RET
  } pc_op_t;

  // Only an active step (step high, stall low) may act; ret outranks everything.
  function automatic pc_op_t encode_op(input logic step, input logic stall,
                                       input logic branch, input logic jump,
                                       input logic call, input logic ret);
    if (!step || stall) return OP_HOLD;
    if (ret)            return OP_RET;
    if (call)           return OP_CALL;
    if (jump)           return OP_JUMP;
    if (branch)         return OP_BRANCH;
    return OP_SEQ;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address LIFO built on a circular write pointer; a push while full
// silently overwrites the oldest entry.
module ras_stack #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  ptr_inc, ptr_dec;

  // ptr_q always names the next free slot, so the top of stack sits just below it.
  assign ptr_inc  = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec  = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - PTR_W'(1);
  assign top_data = mem_q[ptr_dec];
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);

  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_inc;
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_d   = ptr_dec;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: advances the PC on qualified steps and handles
// relative branches, absolute jumps and call/return through a return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              ADDR_W    = 8,
  parameter int              RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              stall,
  input  logic              branch,
  input  logic [ADDR_W-1:0] b_offset,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  pc_op_t            op;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_err_q, ras_err_d;
  logic              ras_push, ras_pop;

  ras_stack #(
    .DEPTH  (RAS_DEPTH),
    .DATA_W (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus1),
    .top_data  (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  assign pc_plus1 = pc_q + ADDR_W'(1);

  // Adding the raw offset bits modulo 2^ADDR_W is exactly a signed offset add.
  always_comb begin
    op        = encode_op(step, stall, branch, jump, call, ret);
    pc_d      = pc_q;
    ras_err_d = ras_err_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    case (op)
      OP_SEQ:    pc_d = pc_plus1;
      OP_BRANCH: pc_d = pc_plus1 + b_offset;
      OP_JUMP:   pc_d = target;
      OP_CALL: begin
        ras_push = 1'b1;
        pc_d     = target;
        if (ras_full) ras_err_d = 1'b1;
      end
      OP_RET: begin
        if (ras_empty) begin
          pc_d      = pc_plus1;
          ras_err_d = 1'b1;
        end else begin
          ras_pop = 1'b1;
          pc_d    = ras_top;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      ras_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ras_err_q <= ras_err_d;
    end
  end

  assign pc      = pc_q;
  assign ras_err = ras_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random steps,
// compared against a behavioural model built on an integer PC and a queue.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       step = 1'b0, stall = 1'b0, branch = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic [7:0] b_offset = '0, target = '0;
  logic [7:0] pc;
  logic       ras_empty, ras_full, ras_err;

  int checkCount = 0;
  int errorCount = 0;

  int modelPc  = 0;
  int modelErr = 0;
  int modelRas[$];

  pc_sequencer #(
    .ADDR_W    (8),
    .RAS_DEPTH (4),
    .RESET_PC  (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .stall     (stall),
    .branch    (branch),
    .b_offset  (b_offset),
    .jump      (jump),
    .call      (call),
    .ret       (ret),
    .target    (target),
    .pc        (pc),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_err   (ras_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".pc"}, int'(pc), modelPc);
    checkOutput({tag, ".empty"}, int'(ras_empty), int'(modelRas.size() == 0));
    checkOutput({tag, ".full"}, int'(ras_full), int'(modelRas.size() == 4));
    checkOutput({tag, ".err"}, int'(ras_err), modelErr);
  endtask

  task automatic modelReset();
    modelPc  = 0;
    modelErr = 0;
    modelRas.delete();
  endtask

  // Reference behaviour: an active step picks the highest-priority request.
  task automatic modelStep(input logic s, input logic st, input logic br, input logic [7:0] off,
                           input logic j, input logic c, input logic r, input logic [7:0] tg);
    int signedOff;
    if (!s || st) return;
    if (r) begin
      if (modelRas.size() > 0) modelPc = modelRas.pop_back();
      else begin
        modelPc  = (modelPc + 1) % 256;
        modelErr = 1;
      end
    end else if (c) begin
      if (modelRas.size() == 4) begin
        void'(modelRas.pop_front());
        modelErr = 1;
      end
      modelRas.push_back((modelPc + 1) % 256);
      modelPc = int'(tg);
    end else if (j) begin
      modelPc = int'(tg);
    end else if (br) begin
      signedOff = (off >= 8'h80) ? int'(off) - 256 : int'(off);
      modelPc   = (modelPc + signedOff + 1 + 256) % 256;
    end else begin
      modelPc = (modelPc + 1) % 256;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic s, input logic st, input logic br,
                               input logic [7:0] off, input logic j, input logic c,
                               input logic r, input logic [7:0] tg);
    @(negedge clk);
    step = s; stall = st; branch = br; b_offset = off;
    jump = j; call = c; ret = r; target = tg;
    modelStep(s, st, br, off, j, c, r, tg);
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic idleInputs();
    @(negedge clk);
    step = 0; stall = 0; branch = 0; jump = 0; call = 0; ret = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    step = 0; stall = 0; branch = 0; jump = 0; call = 0; ret = 0;
    reset = 1'b1;
    modelReset();
    #1;
    checkAll("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    doReset();

    for (int i = 0; i < 300; i++) applyStimulus("seq", 1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    checkOutput("seq300.pc", int'(pc), 8'h2C);

    applyStimulus("jmp10", 1, 0, 0, 8'h00, 1, 0, 0, 8'h10);
    applyStimulus("br+5", 1, 0, 1, 8'h05, 0, 0, 0, 8'h00);
    checkOutput("br+5.const", int'(pc), 8'h16);
    applyStimulus("br-2", 1, 0, 1, 8'hFE, 0, 0, 0, 8'h00);
    checkOutput("br-2.const", int'(pc), 8'h15);
    applyStimulus("stall", 1, 1, 0, 8'h00, 0, 0, 0, 8'h00);
    checkOutput("stall.const", int'(pc), 8'h15);

    applyStimulus("jmp20", 1, 0, 0, 8'h00, 1, 0, 0, 8'h20);
    applyStimulus("call40", 1, 0, 0, 8'h00, 0, 1, 0, 8'h40);
    applyStimulus("call60", 1, 0, 0, 8'h00, 0, 1, 0, 8'h60);
    applyStimulus("ret1", 1, 0, 0, 8'h00, 0, 0, 1, 8'h00);
    checkOutput("nest.ret1", int'(pc), 8'h41);
    applyStimulus("ret2", 1, 0, 0, 8'h00, 0, 0, 1, 8'h00);
    checkOutput("nest.ret2", int'(pc), 8'h21);
    checkOutput("nest.empty", int'(ras_empty), 1);

    applyStimulus("jmp00", 1, 0, 0, 8'h00, 1, 0, 0, 8'h00);
    for (int i = 1; i <= 5; i++)
      applyStimulus("ovfcall", 1, 0, 0, 8'h00, 0, 1, 0, 8'(i * 16));
    checkOutput("ovf.err", int'(ras_err), 1);
    checkOutput("ovf.full", int'(ras_full), 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("ovfret", 1, 0, 0, 8'h00, 0, 0, 1, 8'h00);
      checkOutput("ovfret.const", int'(pc), 8'h41 - 8'(i * 16));
    end
    checkOutput("ovf.empty", int'(ras_empty), 1);

    doReset();
    applyStimulus("jmp50", 1, 0, 0, 8'h00, 1, 0, 0, 8'h50);
    applyStimulus("uflow", 1, 0, 0, 8'h00, 0, 0, 1, 8'h00);
    checkOutput("uflow.pc", int'(pc), 8'h51);
    checkOutput("uflow.err", int'(ras_err), 1);
    applyStimulus("jmp32", 1, 0, 0, 8'h00, 1, 0, 0, 8'h32);
    applyStimulus("call70", 1, 0, 0, 8'h00, 0, 1, 0, 8'h70);
    applyStimulus("allreq", 1, 0, 1, 8'h07, 1, 1, 1, 8'h99);
    checkOutput("allreq.pc", int'(pc), 8'h33);
    checkOutput("allreq.empty", int'(ras_empty), 1);
    applyStimulus("jmpbr", 1, 0, 1, 8'h07, 1, 0, 0, 8'h12);
    checkOutput("jmpbr.pc", int'(pc), 8'h12);

    applyStimulus("jmp05", 1, 0, 0, 8'h00, 1, 0, 0, 8'h05);
    applyStimulus("call10", 1, 0, 0, 8'h00, 0, 1, 0, 8'h10);
    applyStimulus("call77", 1, 0, 0, 8'h00, 0, 1, 0, 8'h77);
    checkOutput("pre_rst.pc", int'(pc), 8'h77);
    @(negedge clk);
    step = 0; call = 0;
    #2 reset = 1'b1;
    modelReset();
    #1;
    checkAll("async_rst");
    @(negedge clk);
    step = 1;
    @(posedge clk);
    #1;
    checkAll("step_in_rst");
    @(negedge clk);
    step = 0;
    reset = 1'b0;
    applyStimulus("post_rst", 1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    checkOutput("post_rst.const", int'(pc), 8'h01);

    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    logic'($urandom_range(0, 3) != 0),
                    logic'($urandom_range(0, 4) == 0),
                    logic'($urandom_range(0, 3) == 0),
                    8'($urandom_range(0, 255)),
                    logic'($urandom_range(0, 5) == 0),
                    logic'($urandom_range(0, 3) == 0),
                    logic'($urandom_range(0, 3) == 0),
                    8'($urandom_range(0, 255)));
    end
    idleInputs();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
